// File: rtl/fwd_hazard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_unit_if
//  Description : Bundle between decode/fetch control and the forwarding and
//                hazard unit of the 5-stage core.
//                master : decode side. It drives the decoded instruction
//                         fields plus flush/hold, and it reads the operand-mux
//                         selects and the load-use stall.
//                slave  : fwd_hazard_unit.
//                Signals:
//                  id_valid, id_rs, id_rt, id_uses_rt, id_dst,
//                  id_reg_write, id_mem_read   decoded instruction
//                  flush                       squash instruction in decode
//                  hold                        global pipeline freeze
//                  fwd_a_sel, fwd_b_sel        EX operand-mux selects
//                  stall                       load-use stall
//                  stall_cnt                   stall cycle count
//                                              (FWD_STALL_CNT_EN only)
//  Config      : FWD_STALL_CNT_EN adds stall_cnt[15:0]
//  Revision    : 1.0  initial release
// ============================================================================
interface fwd_hazard_unit_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_dst;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;
    logic                  hold;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic                  stall;
`ifdef FWD_STALL_CNT_EN
    logic [15:0]           stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_dst,
               id_reg_write, id_mem_read, flush, hold,
        input  fwd_a_sel, fwd_b_sel, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_dst,
               id_reg_write, id_mem_read, flush, hold,
        output fwd_a_sel, fwd_b_sel, stall, stall_cnt
    );
`else
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_dst,
               id_reg_write, id_mem_read, flush, hold,
        input  fwd_a_sel, fwd_b_sel, stall
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_dst,
               id_reg_write, id_mem_read, flush, hold,
        output fwd_a_sel, fwd_b_sel, stall
    );
`endif
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_unit
//  Description : Forwarding and load-use hazard controller for the 5-stage
//                MIPS core. It shadows destination-register information
//                through ID/EX, EX/MEM and MEM/WB. It drives the 2-bit selects
//                of the two EX operand muxes and raises a one-cycle load-use
//                stall toward fetch/decode. It carries no datapath values.
//  Ports       : clk  - core clock, rising edge
//                rst  - asynchronous, active-high reset
//                bus  - fwd_hazard_unit_if.slave, which carries the decode
//                       fields, flush/hold, fwd_a_sel/fwd_b_sel/stall and,
//                       when enabled, stall_cnt
//                Select encoding: 00 register file, 01 MEM/WB result,
//                                 10 EX/MEM result (11 never driven)
//  Config      : FWD_STALL_CNT_EN adds stall_cnt[15:0], which counts cycles
//                with stall=1 && hold=0 and saturates at 16'hFFFF
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    fwd_hazard_unit_if.slave bus
);

    localparam logic [1:0]            c_sel_rf   = 2'b00;
    localparam logic [1:0]            c_sel_wb   = 2'b01;
    localparam logic [1:0]            c_sel_mem  = 2'b10;
    localparam logic [REG_ADDR_W-1:0] c_reg_zero = '0;

    // ------------------------------------------------------------------
    // Stage records
    // ------------------------------------------------------------------
    // ID/EX
    logic                  r_ex_v;
    logic [REG_ADDR_W-1:0] r_ex_rs;
    logic [REG_ADDR_W-1:0] r_ex_rt;
    logic                  r_ex_uses_rt;
    logic [REG_ADDR_W-1:0] r_ex_dst;
    logic                  r_ex_wr;
    logic                  r_ex_mr;
    // EX/MEM
    logic                  r_mem_v;
    logic [REG_ADDR_W-1:0] r_mem_dst;
    logic                  r_mem_wr;
    logic                  r_mem_mr;
    // MEM/WB
    logic                  r_wb_v;
    logic [REG_ADDR_W-1:0] r_wb_dst;
    logic                  r_wb_wr;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic       w_mem_can_fwd;
    logic       w_wb_can_fwd;
    logic [1:0] w_fwd_a_sel;
    logic [1:0] w_fwd_b_sel;
    logic       w_load_in_ex;
    logic       w_id_depends;
    logic       w_stall;
    logic       w_issue;

    // A load's data is not ready at the end of EX, so a load sitting in
    // EX/MEM is never a forwarding source. The stall keeps a dependent
    // instruction from ever needing that path. Register 0 is hard-wired, so
    // it is never a forwarding source either.
    assign w_mem_can_fwd = r_mem_v && r_mem_wr && !r_mem_mr && (r_mem_dst != c_reg_zero);
    assign w_wb_can_fwd  = r_wb_v  && r_wb_wr  && (r_wb_dst != c_reg_zero);

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    always_comb begin
        w_fwd_a_sel = c_sel_rf;
        if (w_mem_can_fwd && (r_mem_dst == r_ex_rs)) begin
            w_fwd_a_sel = c_sel_mem;
        end else if (w_wb_can_fwd && (r_wb_dst == r_ex_rs)) begin
            w_fwd_a_sel = c_sel_wb;
        end
    end

    // Operand B only forwards when the instruction reads rt. For
    // immediate-form instructions, rt is a destination field, not a source.
    always_comb begin
        w_fwd_b_sel = c_sel_rf;
        if (r_ex_uses_rt) begin
            if (w_mem_can_fwd && (r_mem_dst == r_ex_rt)) begin
                w_fwd_b_sel = c_sel_mem;
            end else if (w_wb_can_fwd && (r_wb_dst == r_ex_rt)) begin
                w_fwd_b_sel = c_sel_wb;
            end
        end
    end

    // Load-use: a load in EX whose destination is read by the instruction in
    // decode. A flushed decode slot is discarded anyway, so it never stalls.
    assign w_load_in_ex = r_ex_v && r_ex_mr && (r_ex_dst != c_reg_zero);
    assign w_id_depends = (r_ex_dst == bus.id_rs) ||
                          (bus.id_uses_rt && (r_ex_dst == bus.id_rt));
    assign w_stall      = w_load_in_ex && bus.id_valid && w_id_depends && !bus.flush;

    // Decode enters EX only when it is real, not stalled and not squashed.
    // Otherwise EX receives a bubble.
    assign w_issue      = bus.id_valid && !w_stall && !bus.flush;

    // ------------------------------------------------------------------
    // Stage advance (hold freezes everything)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_v       <= 1'b0;
            r_ex_rs      <= c_reg_zero;
            r_ex_rt      <= c_reg_zero;
            r_ex_uses_rt <= 1'b0;
            r_ex_dst     <= c_reg_zero;
            r_ex_wr      <= 1'b0;
            r_ex_mr      <= 1'b0;
            r_mem_v      <= 1'b0;
            r_mem_dst    <= c_reg_zero;
            r_mem_wr     <= 1'b0;
            r_mem_mr     <= 1'b0;
            r_wb_v       <= 1'b0;
            r_wb_dst     <= c_reg_zero;
            r_wb_wr      <= 1'b0;
        end else if (!bus.hold) begin
            r_wb_v    <= r_mem_v;
            r_wb_dst  <= r_mem_dst;
            r_wb_wr   <= r_mem_wr;

            r_mem_v   <= r_ex_v;
            r_mem_dst <= r_ex_dst;
            r_mem_wr  <= r_ex_wr;
            r_mem_mr  <= r_ex_mr;

            if (w_issue) begin
                r_ex_v       <= 1'b1;
                r_ex_rs      <= bus.id_rs;
                r_ex_rt      <= bus.id_rt;
                r_ex_uses_rt <= bus.id_uses_rt;
                r_ex_dst     <= bus.id_dst;
                r_ex_wr      <= bus.id_reg_write;
                r_ex_mr      <= bus.id_mem_read;
            end else begin
                // The bubble's indices are zeroed too, so a stale source
                // index can never produce a select in a dead cycle.
                r_ex_v       <= 1'b0;
                r_ex_rs      <= c_reg_zero;
                r_ex_rt      <= c_reg_zero;
                r_ex_uses_rt <= 1'b0;
                r_ex_dst     <= c_reg_zero;
                r_ex_wr      <= 1'b0;
                r_ex_mr      <= 1'b0;
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    // ------------------------------------------------------------------
    // Stall cycle counter (saturating)
    // ------------------------------------------------------------------
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_stall && !bus.hold && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.fwd_a_sel = w_fwd_a_sel;
    assign bus.fwd_b_sel = w_fwd_b_sel;
    assign bus.stall     = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_hazard_unit
//  Description : Self-checking bench for fwd_hazard_unit. A table of
//                per-cycle decode inputs and expected selects/stall walks
//                these cases:
//                  - back-to-back dependency
//                  - distance-two dependency, and priority between writers
//                  - load-use stall
//                  - $0 destination
//                  - flush during a load-use hazard
//                  - hold during a hazard
//                A hand-written sequence then covers asynchronous reset
//                mid-hazard.
//  Config      : FWD_STALL_CNT_EN also checks stall_cnt
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fwd_hazard_unit;

    logic clk;
    logic rst;

    int checks;
    int failures;

    fwd_hazard_unit_if #(.REG_ADDR_W(5)) bus ();

    fwd_hazard_unit #(.REG_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ut;
        logic [4:0] dst;
        logic       wr;
        logic       mr;
        logic       fl;
        logic       hd;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       es;
    } vec_t;

    vec_t vecs[$];

    // Valid instruction in decode: fields, flush, hold, expected a/b/stall.
    function automatic vec_t ins(int rs, int rt, int ut, int dst, int wr, int mr,
                                 int fl, int hd, int ea, int eb, int es);
        vec_t r;
        r.v  = 1'b1;
        r.rs = 5'(rs);
        r.rt = 5'(rt);
        r.ut = 1'(ut);
        r.dst = 5'(dst);
        r.wr = 1'(wr);
        r.mr = 1'(mr);
        r.fl = 1'(fl);
        r.hd = 1'(hd);
        r.ea = 2'(ea);
        r.eb = 2'(eb);
        r.es = 1'(es);
        return r;
    endfunction

    // Empty decode slot.
    function automatic vec_t nop(int hd, int ea, int eb, int es);
        vec_t r;
        r = ins(0, 0, 0, 0, 0, 0, 0, hd, ea, eb, es);
        r.v = 1'b0;
        return r;
    endfunction

    task automatic check(string name, int idx, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        bus.id_valid     = t.v;
        bus.id_rs        = t.rs;
        bus.id_rt        = t.rt;
        bus.id_uses_rt   = t.ut;
        bus.id_dst       = t.dst;
        bus.id_reg_write = t.wr;
        bus.id_mem_read  = t.mr;
        bus.flush        = t.fl;
        bus.hold         = t.hd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(nop(0, 0, 0, 0));

        // ---------------- vector table ----------------
        // back-to-back: add $3,$1,$2 ; sub $4,$3,$5
        vecs.push_back(ins(1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ins(3, 5, 1, 4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 2, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        // distance two: add $3 ; nop ; or $6,$5,$3
        vecs.push_back(ins(1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        vecs.push_back(ins(5, 3, 1, 6, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 1, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        // priority: add $3 ; addi $3,$1,1 (rt=3 unused) ; or $6,$5,$3
        vecs.push_back(ins(1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ins(1, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ins(5, 3, 1, 6, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 2, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        // load-use: lw $2,0($1) ; add $4,$2,$2
        vecs.push_back(ins(1, 2, 0, 2, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(ins(2, 2, 1, 4, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(ins(2, 2, 1, 4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 1, 1, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        // $0 destination: addi $0 ; add $2,$0,$0 ; lw $0 ; add $5,$0,$0
        vecs.push_back(ins(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ins(0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        vecs.push_back(ins(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(ins(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        // flush during load-use: lw $2 ; add $4,$2,$2 (flushed) ; or $7,$4,$9
        vecs.push_back(ins(1, 2, 0, 2, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(ins(2, 2, 1, 4, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(ins(4, 9, 1, 7, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        // hold 3 cycles mid-hazard, then hold while forwarding is active
        vecs.push_back(ins(1, 2, 0, 2, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(ins(2, 2, 1, 4, 1, 0, 0, 1, 0, 0, 1));
        vecs.push_back(ins(2, 2, 1, 4, 1, 0, 0, 1, 0, 0, 1));
        vecs.push_back(ins(2, 2, 1, 4, 1, 0, 0, 1, 0, 0, 1));
        vecs.push_back(ins(2, 2, 1, 4, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(ins(2, 2, 1, 4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop(1, 1, 1, 0));
        vecs.push_back(nop(1, 1, 1, 0));
        vecs.push_back(nop(0, 1, 1, 0));
        vecs.push_back(nop(0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0));

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_a", 0, int'(bus.fwd_a_sel), 0);
        check("reset_b", 0, int'(bus.fwd_b_sel), 0);
        check("reset_stall", 0, int'(bus.stall), 0);
`ifdef FWD_STALL_CNT_EN
        check("reset_cnt", 0, int'(bus.stall_cnt), 0);
`endif
        rst = 1'b0;
        #1;
        check("post_reset_a", 0, int'(bus.fwd_a_sel), 0);
        check("post_reset_stall", 0, int'(bus.stall), 0);
        @(posedge clk);
        #1;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check("fwd_a_sel", i, int'(bus.fwd_a_sel), int'(vecs[i].ea));
            check("fwd_b_sel", i, int'(bus.fwd_b_sel), int'(vecs[i].eb));
            check("stall", i, int'(bus.stall), int'(vecs[i].es));
            @(posedge clk);
            #1;
        end
`ifdef FWD_STALL_CNT_EN
        // Stalled cycles without hold: one in the load-use case, one when
        // the hazard is released after the hold.
        check("stall_cnt", 0, int'(bus.stall_cnt), 2);
`endif

        // ---------------- async reset mid-hazard ----------------
        drive(ins(1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0));    // add $3,$1,$2
        @(posedge clk);
        #1;
        drive(ins(3, 6, 0, 6, 1, 1, 0, 0, 0, 0, 0));    // lw $6,0($3)
        @(posedge clk);
        #1;
        drive(ins(6, 6, 1, 7, 1, 0, 0, 0, 0, 0, 0));    // add $7,$6,$6
        @(negedge clk);
        check("pre_rst_a", 0, int'(bus.fwd_a_sel), 2);
        check("pre_rst_b", 0, int'(bus.fwd_b_sel), 0);
        check("pre_rst_stall", 0, int'(bus.stall), 1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_pulse_a", 0, int'(bus.fwd_a_sel), 0);
        check("rst_pulse_stall", 0, int'(bus.stall), 0);
        rst = 1'b0;
        #1;
        check("rst_release_a", 0, int'(bus.fwd_a_sel), 0);
        check("rst_release_b", 0, int'(bus.fwd_b_sel), 0);
        check("rst_release_stall", 0, int'(bus.stall), 0);
`ifdef FWD_STALL_CNT_EN
        check("rst_release_cnt", 0, int'(bus.stall_cnt), 0);
`endif
        @(posedge clk);                                 // add $7 loads normally
        #1;
        drive(ins(7, 7, 1, 8, 1, 0, 0, 0, 0, 0, 0));    // sub $8,$7,$7
        @(negedge clk);
        check("after_rst_stall", 0, int'(bus.stall), 0);
        @(posedge clk);
        #1;
        drive(nop(0, 0, 0, 0));
        @(negedge clk);
        check("after_rst_a", 0, int'(bus.fwd_a_sel), 2);
        check("after_rst_b", 0, int'(bus.fwd_b_sel), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
